axis_slave_fifo: RTL and testbench
==================================

Name: axis_slave_fifo

Overview:
- Parametrised successor to the single-channel handshake slave.
- Accepts a valid/ready stream into a DEPTH-entry first-word-fall-through FIFO and re-issues it on an independent valid/ready output.
- Detects master protocol violations: valid withdrawn, or data changed, while stalled.
- Sits between a bus master model and downstream consumer logic. Replaces fixed two-stage delay buffering with real back-pressure.

Parameters:
- DATA_W, 32, payload width in bits.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), pointer index width; derived, do not override.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data  input  DATA_W  upstream payload.
- valid  input  1  upstream valid.
- ready  output  1  upstream ready (registered).
- data_out  output  DATA_W  downstream payload, equal to the head entry.
- out_valid  output  1  downstream valid; high when the FIFO is not empty.
- out_ready  input  1  downstream ready.
- level  output  ADDR_W+1  current occupancy, 0..DEPTH.
- err_valid_drop  output  1  sticky: valid fell while a beat was stalled.
- err_data_chg  output  1  sticky: data changed while a beat was stalled.
- err_clr  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (rst_n=0, asynchronous): pointers=0, level=0, ready=0, out_valid=0, data_out=0, both error flags=0. Memory contents are not reset.
- ready is a register. Reset value 0. Every cycle it loads (next level < DEPTH), so it goes high on the first clk edge after reset release.
- Push when valid&&ready at a rising edge: write mem[wr_ptr], then wr_ptr+1.
- Pop when out_valid&&out_ready at a rising edge: rd_ptr+1.
- Pointers are ADDR_W+1 bits and wrap naturally. level = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- Latency: a beat pushed at edge N is presented on data_out with out_valid=1 after edge N, i.e. one cycle. No combinational valid-to-out_valid path.
- out_valid = (level != 0). data_out = mem[rd_ptr] while out_valid=1, else 0.
- Simultaneous push and pop: both happen and level is unchanged. This also applies when level=DEPTH-1.
- Full (level=DEPTH): ready=0 from the edge that filled the FIFO. A pop at full raises ready on the next edge; there is no same-cycle pass-through.
- Empty: out_valid=0 and out_ready is ignored. A pop is never counted.
- No path from out_ready to ready within the same cycle.
- Protocol monitor: one register holds the previous cycle's valid&&!ready; another holds the previous data.
  - If the stall flag is set and valid=0 in the current cycle, set err_valid_drop.
  - If the stall flag is set, valid=1, and data differs from the previous value, set err_data_chg.
  - Flags stay set until err_clr=1 at an edge. If err_clr and a new error occur in the same cycle, set wins.
- Reset asserted mid-transfer: FIFO is emptied immediately and in-flight beats are lost. Downstream sees out_valid drop asynchronously.

Optional Feature:
- Macro: AXIS_SLAVE_LAST_EN.
- Defined:
  - Adds ports in_last (input, 1) and out_last (output, 1).
  - The last bit is stored per entry alongside data. out_last follows the head entry and is 0 when empty.
  - Adds output pkt_cnt (ADDR_W+1 bits): count of entries in the FIFO holding last=1. It increments on push-with-last, decrements on pop-with-last, and is unchanged when both occur.
  - err_data_chg also covers in_last changing while stalled.
- Undefined: these ports and logic are absent. Memory width is DATA_W.

Test Plan:
- Reset release, valid=0: ready=0 during reset, 1 one edge after release; level=0, out_valid=0, data_out=0.
- Push 0xA5A5_0001 with out_ready=0: after the edge, out_valid=1, data_out=0xA5A5_0001, level=1. Assert out_ready for one cycle -> level=0, out_valid=0.
- DEPTH=4, continuous pushes 1..5 with out_ready=0:
  - Beats 1-4 accepted; ready=0 after the 4th edge; beat 5 is held by the master.
  - Then out_ready=1: outputs appear in order 1,2,3,4,5 with ready returning to 1 one edge after the first pop.
- Level 3, push and pop in the same cycle, repeated 10 cycles with incrementing data: level stays 3, output order preserved, pointers wrap without loss.
- Fill to full, then drive valid=1 with 0x11 and drop valid next cycle: err_valid_drop=1.
  - Repeat with data changing to 0x22 while stalled: err_data_chg=1.
  - Pulse err_clr: both flags clear.
- With AXIS_SLAVE_LAST_EN: push 3 beats with last on beat 3, then 2 beats with last on beat 5 -> pkt_cnt=2. Pop 3 -> pkt_cnt=1, and out_last=1 was seen on the 3rd pop.

Source files
------------

// File: rtl/axis_slave_fifo.sv
// axis_slave_fifo: valid/ready stream buffered in a DEPTH-entry first-word-fall-through FIFO, with a master protocol monitor.
// Latency: a beat accepted at edge N appears on data_out/out_valid after edge N (one cycle).
// Backpressure: ready is registered and loads (next level < DEPTH); a pop at full reopens ready on the following edge.
//
// Ports: clk/rst_n (async active-low); data/valid/ready upstream; data_out/out_valid/out_ready downstream;
//        level = occupancy 0..DEPTH; err_valid_drop/err_data_chg sticky monitor flags, cleared by err_clr.
// Optional macro AXIS_SLAVE_LAST_EN adds in_last/out_last (stored per entry) and pkt_cnt (entries holding last=1).
module axis_slave_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              err_valid_drop,
    output logic              err_data_chg,
    input  logic              err_clr
`ifdef AXIS_SLAVE_LAST_EN
    ,
    input  logic              in_last,
    output logic              out_last,
    output logic [ADDR_W:0]   pkt_cnt
`endif
);

`ifdef AXIS_SLAVE_LAST_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    logic [MEM_W-1:0]  mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_d;
    logic              ready_q, ready_d;
    logic              stall_q, stall_d;
    logic [MEM_W-1:0]  prev_word_q;
    logic              err_drop_q, err_drop_d;
    logic              err_chg_q, err_chg_d;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  head_word;
    logic              push, pop;
    logic              viol_drop, viol_chg;

    // The stored word carries the last bit when enabled, so the monitor's
    // change detector covers it without extra logic.
`ifdef AXIS_SLAVE_LAST_EN
    assign wr_word = {in_last, data};
`else
    assign wr_word = data;
`endif

    assign head_word = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Extra pointer bit distinguishes full from empty; subtraction wraps naturally.
    assign level     = wr_ptr_q - rd_ptr_q;
    assign out_valid = (level != '0);
    assign data_out  = out_valid ? head_word[DATA_W-1:0] : '0;
    assign ready     = ready_q;

    assign push = valid & ready_q;
    assign pop  = out_valid & out_ready;

    assign wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(push);
    assign rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(pop);
    assign level_d  = wr_ptr_d - rd_ptr_d;
    // ready is computed from registered state only: out_ready influences it
    // through the next edge, never combinationally.
    assign ready_d  = (level_d < FULL_LVL);

    // Monitor: a beat stalled last cycle must be held unchanged this cycle.
    assign viol_drop  = stall_q & ~valid;
    assign viol_chg   = stall_q & valid & (wr_word != prev_word_q);
    assign stall_d    = valid & ~ready_q;
    // Set has priority over clear.
    assign err_drop_d = viol_drop | (err_drop_q & ~err_clr);
    assign err_chg_d  = viol_chg  | (err_chg_q  & ~err_clr);

    assign err_valid_drop = err_drop_q;
    assign err_data_chg   = err_chg_q;

    // Storage is not reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ready_q     <= 1'b0;
            stall_q     <= 1'b0;
            prev_word_q <= '0;
            err_drop_q  <= 1'b0;
            err_chg_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ready_q     <= ready_d;
            stall_q     <= stall_d;
            prev_word_q <= wr_word;
            err_drop_q  <= err_drop_d;
            err_chg_q   <= err_chg_d;
        end
    end

`ifdef AXIS_SLAVE_LAST_EN
    logic [ADDR_W:0] pkt_cnt_q, pkt_cnt_d;
    logic            last_in_push, last_out_pop;

    assign out_last     = out_valid & head_word[DATA_W];
    assign last_in_push = push & in_last;
    assign last_out_pop = pop & head_word[DATA_W];
    // Simultaneous increment and decrement cancel out.
    assign pkt_cnt_d    = pkt_cnt_q + (ADDR_W+1)'(last_in_push) - (ADDR_W+1)'(last_out_pop);
    assign pkt_cnt      = pkt_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_axis_slave_fifo.sv
// tb_axis_slave_fifo: directed scenarios plus randomized traffic against a queue-based reference model.
// The model tracks FIFO contents as a queue and derives ready/level/flags from queue size and input history.
// Outputs are compared one time unit after every rising edge and on reset assertion.
module tb_axis_slave_fifo;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
`ifdef AXIS_SLAVE_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] data = '0;
    logic              valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              err_clr = 1'b0;
    logic              in_last = 1'b0;
    logic              ready;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic [ADDR_W:0]   level;
    logic              err_valid_drop;
    logic              err_data_chg;
`ifdef AXIS_SLAVE_LAST_EN
    logic              out_last;
    logic [ADDR_W:0]   pkt_cnt;
`endif

    axis_slave_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data           (data),
        .valid          (valid),
        .ready          (ready),
        .data_out       (data_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .level          (level),
        .err_valid_drop (err_valid_drop),
        .err_data_chg   (err_data_chg),
        .err_clr        (err_clr)
`ifdef AXIS_SLAVE_LAST_EN
        ,
        .in_last        (in_last),
        .out_last       (out_last),
        .pkt_cnt        (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W:0] mq[$];     // {last, data} per stored beat, head at index 0
    bit              m_ready = 1'b0;
    bit              m_stall = 1'b0;
    bit              m_evd = 1'b0;
    bit              m_edc = 1'b0;
    logic [DATA_W:0] m_prev = '0;

    always @(posedge clk or negedge rst_n) begin
        logic [DATA_W:0] w;
        bit              do_push, do_pop;
        int              lasts;
        if (!rst_n) begin
            mq.delete();
            m_ready = 1'b0;
            m_stall = 1'b0;
            m_evd   = 1'b0;
            m_edc   = 1'b0;
            m_prev  = '0;
        end else begin
            w       = {LAST_EN & in_last, data};
            do_push = valid && m_ready;
            do_pop  = (mq.size() != 0) && out_ready;
            m_evd   = (m_stall && !valid) || (m_evd && !err_clr);
            m_edc   = (m_stall && valid && (w != m_prev)) || (m_edc && !err_clr);
            m_stall = valid && !m_ready;
            m_prev  = w;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(w);
            m_ready = (mq.size() < DEPTH);
        end
        #1;
        if (started) begin
            chk("ready", ready, m_ready);
            chk("out_valid", out_valid, mq.size() != 0);
            chk("level", level, mq.size());
            chk("data_out", data_out, (mq.size() != 0) ? mq[0][DATA_W-1:0] : '0);
            chk("err_valid_drop", err_valid_drop, m_evd);
            chk("err_data_chg", err_data_chg, m_edc);
`ifdef AXIS_SLAVE_LAST_EN
            lasts = 0;
            foreach (mq[k]) lasts += int'(mq[k][DATA_W]);
            chk("out_last", out_last, (mq.size() != 0) ? mq[0][DATA_W] : 1'b0);
            chk("pkt_cnt", pkt_cnt, lasts);
`else
            lasts = 0;
`endif
        end
    end

    // Drive inputs at a falling edge; return at the next falling edge.
    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic o, input logic c, input logic l);
        valid = v; data = d; out_ready = o; err_clr = c; in_last = l;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] got[$];
        bit                sent5;
        bit                acc;
        bit                rdy_s;
        logic              v, l, o;
        logic [DATA_W-1:0] d;

        rst_n = 1'b0;
        @(negedge clk);
        started = 1'b1;

        // Reset, then release with valid low.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_ready", ready, 0);
        chk("rst_level", level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("rel_ready", ready, 1);
        chk("rel_level", level, 0);

        // Single beat in and out.
        cyc(1, 32'hA5A5_0001, 0, 0, 0);
        chk("one_out_valid", out_valid, 1);
        chk("one_data_out", data_out, 32'hA5A5_0001);
        chk("one_level", level, 1);
        cyc(0, 0, 1, 0, 0);
        chk("one_pop_level", level, 0);
        chk("one_pop_out_valid", out_valid, 0);

        // Fill with 1..4, hold 5, then drain in order.
        for (int k = 1; k <= 4; k++) cyc(1, k, 0, 0, 0);
        chk("full_ready", ready, 0);
        chk("full_level", level, 4);
        cyc(1, 5, 0, 0, 0);
        cyc(1, 5, 0, 0, 0);
        chk("held_level", level, 4);
        chk("held_head", data_out, 1);
        sent5 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (out_valid) got.push_back(data_out);
            acc = !sent5 && ready;
            cyc(!sent5, 5, 1, 0, 0);
            if (acc) sent5 = 1'b1;
            if (i == 0) chk("ready_after_first_pop", ready, 1);
        end
        chk("drain_count", got.size(), 5);
        for (int k = 0; k < 5 && k < got.size(); k++) chk("drain_order", got[k], k + 1);

        // Steady state at level 3 with simultaneous push and pop.
        cyc(1, 100, 0, 0, 0);
        cyc(1, 101, 0, 0, 0);
        cyc(1, 102, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            chk("steady_level", level, 3);
            chk("steady_head", data_out, 100 + i);
            cyc(1, 103 + i, 1, 0, 0);
        end
        chk("steady_end_head", data_out, 110);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        chk("steady_drained", level, 0);

        // Protocol violations while full.
        for (int k = 1; k <= 4; k++) cyc(1, k, 0, 0, 0);
        cyc(1, 32'h11, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("err_drop_set", err_valid_drop, 1);
        chk("err_chg_quiet", err_data_chg, 0);
        cyc(1, 32'h11, 0, 0, 0);
        cyc(1, 32'h22, 0, 0, 0);
        chk("err_chg_set", err_data_chg, 1);
        cyc(1, 32'h22, 0, 1, 0);
        chk("err_drop_clr", err_valid_drop, 0);
        chk("err_chg_clr", err_data_chg, 0);
        cyc(1, 32'h22, 1, 0, 0);
        cyc(1, 32'h22, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("err_drop_stays_clr", err_valid_drop, 0);
        chk("err_refill_level", level, 4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        chk("err_drained", level, 0);

        // Reset asserted mid-transfer.
        cyc(1, 7, 0, 0, 0);
        cyc(1, 8, 0, 0, 0);
        chk("mid_level", level, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_ready", ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("mid_rel_ready", ready, 1);

`ifdef AXIS_SLAVE_LAST_EN
        // Packet counting with last markers on beats 3 and 5.
        for (int k = 1; k <= 4; k++) cyc(1, k, 0, 0, k == 3);
        chk("pkt_after4", pkt_cnt, 1);
        cyc(1, 5, 1, 0, 1);
        cyc(1, 5, 0, 0, 1);
        chk("pkt_after5", pkt_cnt, 2);
        chk("pkt_head2_last", out_last, 0);
        cyc(0, 0, 1, 0, 0);
        chk("pkt_third_pop_last", out_last, 1);
        chk("pkt_third_pop_data", data_out, 3);
        cyc(0, 0, 1, 0, 0);
        chk("pkt_after_pops", pkt_cnt, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("pkt_drained", pkt_cnt, 0);
`endif

        // Randomized traffic; mostly protocol-compliant, occasional violations and clears.
        rdy_s = ready;
        for (int i = 0; i < 3000; i++) begin
            if (valid && !rdy_s && $urandom_range(0, 49) != 0) begin
                v = 1'b1; d = data; l = in_last;
            end else begin
                v = ($urandom_range(0, 2) != 0);
                d = $urandom;
                l = ($urandom_range(0, 3) == 0);
            end
            o = ($urandom_range(0, 3) < (((i / 400) % 2 == 1) ? 1 : 3));
            rdy_s = ready;
            cyc(v, d, o, ($urandom_range(0, 39) == 0), l);
        end
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);
        chk("final_level", level, 0);
        chk("final_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
